// File: rtl/sobel_mem_row_reader.sv
// sobel_mem_row_reader: Avalon-MM read master that streams consecutive
// 1024-bit pixel rows from the on-chip memory to the Sobel datapath.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               1-cycle pulse, accepted only in idle
//   base_addr           first word address, sampled on accepted start
//   word_count          number of words (0..2**ADDR_W), sampled on start
//   busy, done          transfer in progress / 1-cycle completion pulse
//   avm_*               Avalon-MM master to the memory s1 slave
//   out_data/valid/
//   ready/last          valid/ready row stream, out_last on final word
//   stall_cycles        (STALL_COUNT_EN only) stalled-output cycle count
//
// Build option: define STALL_COUNT_EN to add the stall_cycles counter.
module sobel_mem_row_reader #(
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 1024,
   parameter int BE_W      = 128,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   output logic [BE_W-1:0]   avm_byteenable,
   output logic              avm_clken,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef STALL_COUNT_EN
   output logic              out_last,
   output logic [15:0]       stall_cycles
`else
   output logic              out_last
`endif
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W:0] DEPTH = (OCC_W+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  issued;
   logic              pend;
   logic              pend_last;
   logic              done_q;

   logic [DATA_W-1:0]    buf_data [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] buf_last;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [OCC_W-1:0]     occ;

   logic             accept;
   logic             first_rd;
   logic             more_rd;
   logic             issue_last;
   logic             pop;
   logic [OCC_W:0]   load;

   assign avm_write      = 1'b0;
   assign avm_writedata  = '0;
   assign avm_byteenable = '1;
   assign avm_clken      = 1'b1;

   assign busy = (state != S_IDLE);
   assign done = done_q;

   // The done cycle is still idle but must not accept a new start.
   assign accept   = start & (state == S_IDLE) & ~done_q;
   // First read goes out in the start cycle itself so rows appear early.
   assign first_rd = accept & (word_count != '0);

   assign out_valid = (occ != '0);
   assign out_data  = buf_data[rd_ptr];
   assign out_last  = out_valid & buf_last[rd_ptr];
   assign pop       = out_valid & out_ready;

   // Entries the buffer will hold after this cycle, counting the read
   // whose data arrives now and crediting this cycle's pop. A new read
   // lands one cycle later, so issue only while this stays below depth;
   // the pop credit is what allows one word per cycle with depth 2.
   assign load = {1'b0, occ}
               + {{OCC_W{1'b0}}, pend}
               - {{OCC_W{1'b0}}, pop};

   assign more_rd = (state == S_READ)
                  & (issued != count_q)
                  & (load < DEPTH);

   assign avm_chipselect = first_rd | more_rd;
   assign avm_address    = first_rd ? base_addr
                                    : base_q + issued[ADDR_W-1:0];
   assign issue_last     = first_rd ? (word_count == CNT_W'(1))
                                    : (issued == count_q - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (pend) begin
         buf_data[wr_ptr] <= avm_readdata;
         buf_last[wr_ptr] <= pend_last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         base_q    <= '0;
         count_q   <= '0;
         issued    <= '0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
         done_q    <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
      end else begin
         done_q    <= 1'b0;
         pend      <= avm_chipselect;
         pend_last <= avm_chipselect & issue_last;
         if (pend)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         occ <= occ + OCC_W'(pend) - OCC_W'(pop);
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  base_q  <= base_addr;
                  count_q <= word_count;
                  if (word_count == '0) begin
                     issued <= '0;
                     done_q <= 1'b1;
                  end else begin
                     issued <= CNT_W'(1);
                     state  <= (word_count == CNT_W'(1)) ? S_DRAIN
                                                         : S_READ;
                  end
               end
            end
            S_READ: begin
               if (more_rd) begin
                  issued <= issued + CNT_W'(1);
                  if (issue_last)
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop & out_last) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= '0;
      else if (accept)
         stall_cycles <= '0;
      else if (busy & out_valid & ~out_ready
               & (stall_cycles != 16'hFFFF))
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sobel_mem_row_reader.sv
// tb_sobel_mem_row_reader: randomized bench with a memory model and a
// queue-based expectation of the row stream for sobel_mem_row_reader.
module tb_sobel_mem_row_reader;

   localparam int AW = 6;
   localparam int DW = 1024;
   localparam int BW = 128;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   word_count;
   logic          busy;
   logic          done;
   logic [AW-1:0] avm_address;
   logic          avm_chipselect;
   logic          avm_write;
   logic [DW-1:0] avm_writedata;
   logic [BW-1:0] avm_byteenable;
   logic          avm_clken;
   logic [DW-1:0] avm_readdata;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
`ifdef STALL_COUNT_EN
   logic [15:0]   stall_cycles;
`endif

   sobel_mem_row_reader dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .busy           (busy),
      .done           (done),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write      (avm_write),
      .avm_writedata  (avm_writedata),
      .avm_byteenable (avm_byteenable),
      .avm_clken      (avm_clken),
      .avm_readdata   (avm_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
`ifdef STALL_COUNT_EN
      .out_last       (out_last),
      .stall_cycles   (stall_cycles)
`else
      .out_last       (out_last)
`endif
   );

   logic [DW-1:0] mem [64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory, one-cycle read latency.
   always @(posedge clk)
      if (avm_chipselect)
         avm_readdata <= mem[avm_address];

   int n_checks;
   int n_pass;

   logic [DW-1:0] got_data [$];
   logic          got_last [$];
   int            addr_q [$];
   int            done_cyc;
   int            first_valid;
   int            done_pulses;
   int            max_out;
   int            unstable;
   int            stall_model;
   int            last_hs;
   int            last_cs;
   logic          busy_at_done;

   function automatic logic ready_for(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 3 == 0);
      return 1'($urandom % 2);
   endfunction

   // Drives one transfer (optionally a second start at inj_cyc) and
   // records what the stream and memory port did, cycle 0 = start cycle.
   task automatic run_xfer(input int b, input int c, input int mode,
                           input int inj_cyc, input int inj_b,
                           input int inj_c);
      logic [DW-1:0] pd;
      logic          pl;
      logic          pstall;
      int            iss;
      int            pop;
      int            lim;
      got_data.delete();
      got_last.delete();
      addr_q.delete();
      done_cyc = -1; first_valid = -1; done_pulses = 0;
      max_out = 0; unstable = 0; stall_model = 0;
      last_hs = -1; last_cs = -1; busy_at_done = 1'bx;
      pd = '0; pl = 1'b0; pstall = 1'b0; iss = 0; pop = 0;
      lim = 8 * c + 20;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < lim; cyc++) begin
         if (cyc == 0) begin
            start = 1'b1; base_addr = AW'(b); word_count = (AW+1)'(c);
         end else if (cyc == inj_cyc) begin
            start = 1'b1; base_addr = AW'(inj_b);
            word_count = (AW+1)'(inj_c);
         end else begin
            start = 1'b0;
         end
         out_ready = ready_for(mode, cyc);
         @(negedge clk);
         if (avm_chipselect) begin
            addr_q.push_back(int'(avm_address)); iss++; last_cs = cyc;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (pstall && (out_valid !== 1'b1 || out_data !== pd
                        || out_last !== pl))
            unstable++;
         if (busy && out_valid && !out_ready) stall_model++;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data); got_last.push_back(out_last);
            pop++; last_hs = cyc;
         end
         if (iss - pop > max_out) max_out = iss - pop;
         if (done === 1'b1) begin
            done_pulses++;
            if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
         end
         pstall = out_valid && !out_ready; pd = out_data; pl = out_last;
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_checks++;
      if (done_cyc < 0)
         $display("FAIL xfer_timeout: no done within %0d cycles (base %0d count %0d)", lim, b, c);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      out_ready = 1'b0; avm_readdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
      n_checks++; if (avm_chipselect !== 1'b0) $display("FAIL rst_cs: got %b want 0", avm_chipselect); else n_pass++;
      n_checks++; if (avm_address !== '0) $display("FAIL rst_addr: got %0d want 0", avm_address); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", out_last); else n_pass++;
      n_checks++;
      if (avm_write !== 1'b0 || avm_writedata !== '0 || avm_byteenable !== '1 || avm_clken !== 1'b1)
         $display("FAIL rst_ties: got wr %b be_allones %b clken %b want 0/1/1", avm_write, avm_byteenable === '1, avm_clken);
      else n_pass++;
`ifdef STALL_COUNT_EN
      n_checks++; if (stall_cycles !== 16'd0) $display("FAIL rst_stall: got %0d want 0", stall_cycles); else n_pass++;
`endif
   endtask

   task automatic test_basic();
      logic [DW-1:0] w;
      logic [DW-1:0] e;
      run_xfer(5, 3, 0, -1, 0, 0);
      n_checks++; if (addr_q.size() != 3) $display("FAIL basic_ncs: got %0d want 3", addr_q.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= addr_q.size()) $display("FAIL basic_addr[%0d]: missing want %0d", i, 5 + i);
         else if (addr_q[i] != 5 + i) $display("FAIL basic_addr[%0d]: got %0d want %0d", i, addr_q[i], 5 + i);
         else n_pass++;
      end
      n_checks++; if (last_cs != 2) $display("FAIL basic_cs_consec: last cs cycle %0d want 2", last_cs); else n_pass++;
      n_checks++; if (first_valid != 2) $display("FAIL basic_first_valid: got %0d want 2", first_valid); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         e = mem[5 + i];
         n_checks++;
         if (i >= got_data.size()) $display("FAIL basic_data[%0d]: missing", i);
         else begin
            w = got_data[i];
            if (w !== e || got_last[i] !== (i == 2))
               $display("FAIL basic_data[%0d]: got %h/%b want %h/%b", i, w[31:0], got_last[i], e[31:0], i == 2);
            else n_pass++;
         end
      end
      n_checks++; if (done_cyc != 5) $display("FAIL basic_done_cyc: got %0d want 5", done_cyc); else n_pass++;
      n_checks++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", busy_at_done); else n_pass++;
      n_checks++; if (done_pulses != 1) $display("FAIL basic_done_pulse: got %0d want 1", done_pulses); else n_pass++;
   endtask

   task automatic test_wrap();
      int tb_base [2] = '{62, 0};
      int tb_cnt  [2] = '{4, 64};
      int b;
      int c;
      int bad;
      for (int t = 0; t < 2; t++) begin
         b = tb_base[t]; c = tb_cnt[t];
         run_xfer(b, c, 0, -1, 0, 0);
         bad = 0;
         for (int i = 0; i < c; i++)
            if (i >= addr_q.size() || addr_q[i] != (b + i) % 64) bad++;
         n_checks++;
         if (addr_q.size() != c || bad != 0)
            $display("FAIL wrap_addr b%0d c%0d: got %0d reads %0d bad want %0d reads 0 bad", b, c, addr_q.size(), bad, c);
         else n_pass++;
         bad = 0;
         for (int i = 0; i < c; i++)
            if (i >= got_data.size() || got_data[i] !== mem[(b + i) % 64] || got_last[i] !== (i == c - 1)) bad++;
         n_checks++;
         if (got_data.size() != c || bad != 0)
            $display("FAIL wrap_data b%0d c%0d: got %0d words %0d bad want %0d words 0 bad", b, c, got_data.size(), bad, c);
         else n_pass++;
         n_checks++;
         if (done_cyc != c + 2) $display("FAIL wrap_done_cyc c%0d: got %0d want %0d", c, done_cyc, c + 2);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int b;
      int bad;
      b = int'($urandom % 64);
      run_xfer(b, 8, 1, -1, 0, 0);
      n_checks++; if (max_out > 2) $display("FAIL bp_outstanding: got %0d want <=2", max_out); else n_pass++;
      n_checks++; if (unstable != 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else n_pass++;
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (i >= got_data.size() || got_data[i] !== mem[(b + i) % 64] || got_last[i] !== (i == 7)) bad++;
      n_checks++;
      if (got_data.size() != 8 || bad != 0)
         $display("FAIL bp_data: got %0d words %0d bad want 8 words 0 bad", got_data.size(), bad);
      else n_pass++;
      n_checks++; if (done_cyc != last_hs + 1) $display("FAIL bp_done_cyc: got %0d want %0d", done_cyc, last_hs + 1); else n_pass++;
`ifdef STALL_COUNT_EN
      n_checks++; if (int'(stall_cycles) != stall_model) $display("FAIL bp_stall: got %0d want %0d", stall_cycles, stall_model); else n_pass++;
`endif
   endtask

   task automatic test_edge_starts();
      int bad;
      run_xfer(9, 0, 0, -1, 0, 0);
      n_checks++; if (done_cyc != 1) $display("FAIL zero_done_cyc: got %0d want 1", done_cyc); else n_pass++;
      n_checks++; if (addr_q.size() != 0) $display("FAIL zero_cs: got %0d want 0", addr_q.size()); else n_pass++;
      n_checks++; if (first_valid != -1) $display("FAIL zero_valid: got cycle %0d want none", first_valid); else n_pass++;
      // Second start while busy must be ignored.
      run_xfer(10, 8, 1, 3, 40, 3);
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (i >= got_data.size() || got_data[i] !== mem[10 + i]) bad++;
      n_checks++;
      if (got_data.size() != 8 || bad != 0 || addr_q.size() != 8)
         $display("FAIL busy_start: got %0d words %0d bad %0d reads want 8/0/8", got_data.size(), bad, addr_q.size());
      else n_pass++;
      n_checks++; if (done_pulses != 1) $display("FAIL busy_start_done: got %0d want 1", done_pulses); else n_pass++;
      // Start arriving in the done cycle must be ignored.
      run_xfer(20, 3, 0, 5, 30, 2);
      n_checks++;
      if (addr_q.size() != 3 || busy !== 1'b0)
         $display("FAIL done_start: got %0d reads busy %b want 3 reads busy 0", addr_q.size(), busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int hs;
      int dn;
      int vld;
      int bad;
      @(posedge clk); #1;
      start = 1'b1; base_addr = '0; word_count = 7'd10; out_ready = 1'b1;
      hs = 0;
      for (int k = 0; k < 50 && hs < 3; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) hs++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      n_checks++; if (hs != 3) $display("FAIL mid_progress: got %0d words want 3", hs); else n_pass++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || avm_chipselect !== 1'b0 || avm_address !== '0 || out_valid !== 1'b0 || out_last !== 1'b0)
         $display("FAIL mid_reset_outs: got busy%b done%b cs%b addr%0d vld%b last%b want all 0",
                  busy, done, avm_chipselect, avm_address, out_valid, out_last);
      else n_pass++;
      dn = 0; vld = 0;
      repeat (5) begin
         @(negedge clk);
         dn += int'(done); vld += int'(out_valid);
      end
      n_checks++; if (dn != 0 || vld != 0) $display("FAIL mid_no_done: got done %0d valid %0d want 0/0", dn, vld); else n_pass++;
      run_xfer(0, 10, 0, -1, 0, 0);
      bad = 0;
      for (int i = 0; i < 10; i++)
         if (i >= got_data.size() || got_data[i] !== mem[i] || i >= addr_q.size() || addr_q[i] != i) bad++;
      n_checks++;
      if (got_data.size() != 10 || bad != 0)
         $display("FAIL mid_restart: got %0d words %0d bad want 10/0", got_data.size(), bad);
      else n_pass++;
   endtask

   task automatic test_random();
      int b;
      int c;
      int bad;
      for (int t = 0; t < 6; t++) begin
         b = int'($urandom % 64);
         c = int'($urandom_range(1, 20));
         run_xfer(b, c, 2, -1, 0, 0);
         bad = 0;
         for (int i = 0; i < c; i++)
            if (i >= got_data.size() || got_data[i] !== mem[(b + i) % 64] || got_last[i] !== (i == c - 1)) bad++;
         n_checks++;
         if (got_data.size() != c || bad != 0 || max_out > 2 || unstable != 0)
            $display("FAIL rand_%0d b%0d c%0d: got %0d words %0d bad out %0d unst %0d want %0d/0/<=2/0",
                     t, b, c, got_data.size(), bad, max_out, unstable, c);
         else n_pass++;
`ifdef STALL_COUNT_EN
         n_checks++; if (int'(stall_cycles) != stall_model) $display("FAIL rand_stall_%0d: got %0d want %0d", t, stall_cycles, stall_model); else n_pass++;
`endif
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int a = 0; a < 64; a++)
         for (int k = 0; k < DW / 32; k++)
            mem[a][k*32 +: 32] = $urandom;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_edge_starts();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
